// File: rtl/rx_samp_readout.sv
// rx_samp_readout: ring-buffers 24-bit I/Q samples and streams a header plus an NSAMP block as 16-bit words.
// The read address follows rd_ptr_d, so sample data is already registered by the time FETCH hands off to W0.
module rx_samp_readout #(
    parameter int NSAMP = 170,
    parameter int DEPTH = 1024,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic        hb_clk,
    input  logic        hb_rst_n,
    input  logic        samp_wr,
    input  logic [23:0] samp_i,
    input  logic [23:0] samp_q,
    input  logic        rd_start,
    input  logic        ovfl_clr,
    output logic        rx_rd,
    output logic [15:0] rx_dout,
    output logic        rx_busy,
    output logic        rx_avail,
    output logic        rx_ovfl
);
    typedef enum logic [2:0] {IDLE, HDR, FETCH, W0, W1, W2} state_t;
    localparam int SW = $clog2(NSAMP + 1);
    localparam logic [AW:0] NS = (AW + 1)'(NSAMP);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PONE = (AW + 1)'(1);

    logic [47:0]   mem [DEPTH];
    logic [47:0]   rdata_q;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
    state_t        state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          short_q, short_d, ovfl_q, ovfl_d, avail_q, avail_d, rd_q, rd_d, wr_en;
    logic [15:0]   dout_q, dout_d;
    logic [31:0]   cnt32;
    logic [13:0]   cnt_snap;

    always_comb begin
        count = wr_ptr_q - rd_ptr_q;
        wr_en = samp_wr && (count != FULL);
        wr_ptr_d = wr_en ? wr_ptr_q + PONE : wr_ptr_q;
        ovfl_d = (samp_wr && !wr_en) || (ovfl_q && !ovfl_clr);
        avail_d = count >= NS;
        cnt32 = 32'(count);
        cnt_snap = (cnt32 > 32'd16383) ? 14'h3fff : cnt32[13:0];
    end

    always_comb begin
        state_d = state_q;
        rd_ptr_d = rd_ptr_q;
        scnt_d = scnt_q;
        short_d = short_q;
        rd_d = 1'b0;
        dout_d = 16'h0000;
        case (state_q)
            IDLE: if (rd_start) begin
                state_d = HDR;
                short_d = ~avail_q;
                rd_d = 1'b1;
                dout_d = {ovfl_q, ~avail_q, cnt_snap};
            end
            HDR: begin
                state_d = short_q ? IDLE : FETCH;
                scnt_d = '0;
            end
            FETCH: begin
                state_d = W0;
                rd_d = 1'b1;
                dout_d = rdata_q[47:32];
            end
            W0: begin
                state_d = W1;
                rd_d = 1'b1;
                dout_d = rdata_q[23:8];
            end
            W1: begin
                state_d = W2;
                rd_d = 1'b1;
                dout_d = {rdata_q[31:24], rdata_q[7:0]};
            end
            W2: begin
                rd_ptr_d = rd_ptr_q + PONE;
                state_d = (scnt_q == SW'(NSAMP - 1)) ? IDLE : FETCH;
                scnt_d = scnt_q + SW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hb_clk) begin
        if (!hb_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= IDLE;
            scnt_q   <= '0;
            short_q  <= 1'b0;
            ovfl_q   <= 1'b0;
            avail_q  <= 1'b0;
            rd_q     <= 1'b0;
            dout_q   <= 16'h0000;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            scnt_q   <= scnt_d;
            short_q  <= short_d;
            ovfl_q   <= ovfl_d;
            avail_q  <= avail_d;
            rd_q     <= rd_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge hb_clk) begin
        if (wr_en && hb_rst_n) mem[wr_ptr_q[AW-1:0]] <= {samp_i, samp_q};
        rdata_q <= mem[rd_ptr_d[AW-1:0]];
    end

    assign rx_rd    = rd_q;
    assign rx_dout  = dout_q;
    assign rx_busy  = state_q != IDLE;
    assign rx_avail = avail_q;
    assign rx_ovfl  = ovfl_q;
endmodule
